// File: rtl/dt_engine.sv
// In-place two-pass chamfer distance transform over an external single-port SRAM.
// Define DT_MODE_8N_EN to build the chessboard (8-neighbour) slots and honour `mode`.
module dt_engine #(
    parameter int unsigned IMG_W  = 640,
    parameter int unsigned IMG_H  = 480,
    parameter int unsigned PIX_W  = 8,
    parameter int unsigned X_W    = 10,
    parameter int unsigned ADDR_W = 20
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              mode,
    output logic              busy,
    output logic              done,
    output logic              mem_ce,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [PIX_W-1:0]  mem_wdata,
    input  logic [PIX_W-1:0]  mem_rdata
);

    localparam int unsigned Y_W  = ADDR_W - X_W;
    localparam int unsigned PH_W = 3;
    localparam logic [PIX_W-1:0] MAXV   = '1;
    localparam logic [X_W-1:0]   X_LAST = X_W'(IMG_W - 1);
    localparam logic [Y_W-1:0]   Y_LAST = Y_W'(IMG_H - 1);
`ifdef DT_MODE_8N_EN
    localparam bit HAS_8N = 1'b1;
`else
    localparam bit HAS_8N = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, FWD, BWD, DONE} state_t;

    state_t            state;
    logic              mode_q;
    logic [PH_W-1:0]   ph;
    logic [X_W-1:0]    x;
    logic [Y_W-1:0]    y;
    logic [PIX_W-1:0]  acc;
    logic              rd_vld;

    logic [PH_W-1:0]   n_slots;
    logic [PH_W-1:0]   wr_ph;
    logic [PH_W-1:0]   nph;
    logic [X_W-1:0]    nx, sx;
    logic [Y_W-1:0]    ny, sy;
    logic              pass_end;
    logic              s_vld;
    logic              lft, rgt, top, bot;
    logic [PIX_W-1:0]  val, inc, acc_nxt;

    assign n_slots = mode_q ? PH_W'(5) : PH_W'(3);
    assign wr_ph   = n_slots + PH_W'(1);

    // Next pixel position / phase; a pass ends on the write cycle of its last pixel.
    always_comb begin
        nph      = ph + PH_W'(1);
        nx       = x;
        ny       = y;
        pass_end = 1'b0;
        if (ph == wr_ph) begin
            nph = '0;
            if (state == BWD) begin
                if (x == '0) begin
                    nx       = X_LAST;
                    ny       = y - Y_W'(1);
                    pass_end = (y == '0);
                end else begin
                    nx = x - X_W'(1);
                end
            end else begin
                if (x == X_LAST) begin
                    nx       = '0;
                    ny       = y + Y_W'(1);
                    pass_end = (y == Y_LAST);
                end else begin
                    nx = x + X_W'(1);
                end
            end
            if (pass_end) begin
                nx = X_LAST;
                ny = Y_LAST;
            end
        end
    end

    // Neighbour address and in-image test for the slot issued in the next cycle.
    always_comb begin
        s_vld = 1'b0;
        sx    = nx;
        sy    = ny;
        lft   = (nx != '0);
        rgt   = (nx != X_LAST);
        top   = (ny != '0);
        bot   = (ny != Y_LAST);
        case (nph)
            PH_W'(0): s_vld = 1'b1;
            PH_W'(1): begin
                if (state == BWD) begin
                    sx    = nx + X_W'(1);
                    s_vld = rgt;
                end else begin
                    sx    = nx - X_W'(1);
                    s_vld = lft;
                end
            end
            PH_W'(2): begin
                if (state == BWD) begin
                    sy    = ny + Y_W'(1);
                    s_vld = bot;
                end else begin
                    sy    = ny - Y_W'(1);
                    s_vld = top;
                end
            end
`ifdef DT_MODE_8N_EN
            PH_W'(3): begin
                if (state == BWD) begin
                    sx    = nx + X_W'(1);
                    sy    = ny + Y_W'(1);
                    s_vld = rgt && bot;
                end else begin
                    sx    = nx - X_W'(1);
                    sy    = ny - Y_W'(1);
                    s_vld = lft && top;
                end
            end
            PH_W'(4): begin
                if (state == BWD) begin
                    sx    = nx - X_W'(1);
                    sy    = ny + Y_W'(1);
                    s_vld = lft && bot;
                end else begin
                    sx    = nx + X_W'(1);
                    sy    = ny - Y_W'(1);
                    s_vld = rgt && top;
                end
            end
`endif
            default: ;
        endcase
    end

    // Running minimum; skipped slots contribute MAXV and increments saturate.
    always_comb begin
        val = rd_vld ? mem_rdata : MAXV;
        inc = (val == MAXV) ? MAXV : val + PIX_W'(1);
        if (ph == PH_W'(1)) begin
            if (state == BWD) acc_nxt = val;
            else              acc_nxt = (val == '0) ? '0 : MAXV;
        end else begin
            acc_nxt = (inc < acc) ? inc : acc;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            mode_q    <= 1'b0;
            ph        <= '0;
            x         <= '0;
            y         <= '0;
            acc       <= '0;
            rd_vld    <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            mem_ce    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done   <= 1'b0;
                    rd_vld <= 1'b0;
                    if (start) begin
                        state    <= FWD;
                        mode_q   <= mode & HAS_8N;
                        ph       <= '0;
                        x        <= '0;
                        y        <= '0;
                        busy     <= 1'b1;
                        mem_ce   <= 1'b1;
                        mem_we   <= 1'b0;
                        mem_addr <= '0;
                    end
                end
                FWD, BWD: begin
                    rd_vld <= mem_ce && !mem_we;
                    if (ph >= PH_W'(1) && ph <= n_slots) acc <= acc_nxt;
                    if (ph == n_slots) mem_wdata <= acc_nxt;
                    ph       <= nph;
                    x        <= nx;
                    y        <= ny;
                    mem_ce   <= (nph < n_slots) ? s_vld : (nph == wr_ph);
                    mem_we   <= (nph == wr_ph);
                    mem_addr <= {sy, sx};
                    if (pass_end) begin
                        if (state == FWD) begin
                            state <= BWD;
                        end else begin
                            state  <= DONE;
                            busy   <= 1'b0;
                            done   <= 1'b1;
                            mem_ce <= 1'b0;
                            mem_we <= 1'b0;
                        end
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
